// File: rtl/bcd_conv_pkg.sv
// Shared types and constants for the time-shared binary-to-BCD scheduler.
// Latency: none (declarations and a constant function only).
// Backpressure: not applicable.
package bcd_conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Double-dabble correction: a digit at or above 5 gets 3 added before the shift
  localparam int ADD3_THRESH = 5;
  localparam int ADD3_VAL    = 3;

  // Smallest digit count d with 10^d > 2^bin_w - 1; used for elaboration checks
  function automatic int digits_needed(input int bin_w);
    logic [63:0] max_v;
    logic [63:0] p;
    int          d;
    max_v = (64'd1 << bin_w) - 64'd1;
    p     = 64'd10;
    d     = 1;
    for (int i = 0; i < 19; i++) begin
      if (p <= max_v) begin
        p = p * 64'd10;
        d = d + 1;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_conv_sched_if.sv
// Request/grant/result bundle between requesters and the shared BCD engine.
// Latency: none (wires only).
// Backpressure: req is a level held until gnt; results are a done pulse with held data.
interface bcd_conv_sched_if #(
  parameter int N_REQ = 4,
  parameter int BIN_W = 16,
  parameter int DIG   = 5,
  parameter int ID_W  = $clog2(N_REQ)
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*BIN_W-1:0] bin_in;
  logic [N_REQ-1:0]       gnt;
  logic                   busy;
  logic                   done;
  logic [ID_W-1:0]        done_id;
  logic [4*DIG-1:0]       bcd_out;

  // Requester side
  modport master (
    output req, bin_in,
    input  gnt, busy, done, done_id, bcd_out
  );

  // Scheduler side
  modport slave (
    input  req, bin_in,
    output gnt, busy, done, done_id, bcd_out
  );
endinterface

// File: rtl/bcd_dd_engine.sv
// Iterative shift-and-add-3 engine: one binary bit moves into the BCD digits per step.
// Latency: BIN_W steps after load; bcd shows the digits that the current step produces.
// Backpressure: none; the caller sequences load/step.
module bcd_dd_engine
  import bcd_conv_pkg::*;
#(
  parameter int BIN_W = 16,
  parameter int DIG   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [BIN_W-1:0] bin,
  input  logic             step,
  output logic [4*DIG-1:0] bcd
);
  localparam int SR_W = 4*DIG + BIN_W;

  logic [SR_W-1:0] sr_q, sr_d;
  logic [SR_W-1:0] sr_adj;
  logic [SR_W-1:0] sr_step;

  // Per-digit correction on the BCD half; the binary half passes through untouched
  assign sr_adj[BIN_W-1:0] = sr_q[BIN_W-1:0];
  for (genvar g = 0; g < DIG; g++) begin : g_dig
    logic [3:0] dig;
    assign dig = sr_q[BIN_W + 4*g +: 4];
    assign sr_adj[BIN_W + 4*g +: 4] = (dig >= 4'(ADD3_THRESH)) ? dig + 4'(ADD3_VAL) : dig;
  end

  assign sr_step = {sr_adj[SR_W-2:0], 1'b0};

  // Exposing the post-step digits lets the scheduler capture the final result
  // on the same edge as the last shift
  assign bcd = sr_step[SR_W-1 -: 4*DIG];

  // Next shift-register value: load a fresh operand or advance one step
  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = {{(4*DIG){1'b0}}, bin};
    end else if (step) begin
      sr_d = sr_step;
    end
  end

  // Shift register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

endmodule

// File: rtl/bcd_conv_sched.sv
// Round-robin scheduler sharing one binary-to-BCD engine among N_REQ requesters.
// Latency: gnt one cycle after req is seen in IDLE; done BIN_W cycles after gnt; BIN_W+2 per conversion.
// Backpressure: requesters hold req/bin_in until gnt; req is ignored while busy.
module bcd_conv_sched
  import bcd_conv_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int BIN_W = 16,
  parameter int DIG   = 5,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic           clk,
  input  logic           rst_n,
  bcd_conv_sched_if.slave bus
);
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  if (DIG < digits_needed(BIN_W)) begin : g_bad_dig
    $error("bcd_conv_sched: DIG too small for BIN_W");
  end
  if (N_REQ < 2) begin : g_bad_nreq
    $error("bcd_conv_sched: N_REQ must be at least 2");
  end

  state_e             state_q, state_d;
  logic [ID_W-1:0]    rr_q, rr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic               done_q, done_d;
  logic [ID_W-1:0]    done_id_q, done_id_d;
  logic [ID_W-1:0]    tag_q, tag_d;
  logic [4*DIG-1:0]   bcd_q, bcd_d;

  logic               win_vld;
  logic [ID_W-1:0]    win_idx;
  logic [BIN_W-1:0]   eng_bin;
  logic [4*DIG-1:0]   eng_bcd;
  logic               eng_load;
  logic               eng_step;

  // Round-robin pick: first set req at or above the pointer, wrapping
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_vld && bus.req[(int'(rr_q) + i) % N_REQ]) begin
        win_vld = 1'b1;
        win_idx = ID_W'((int'(rr_q) + i) % N_REQ);
      end
    end
  end

  assign eng_bin  = bus.bin_in[int'(win_idx)*BIN_W +: BIN_W];
  assign eng_load = (state_q == IDLE) && win_vld;
  assign eng_step = (state_q == SHIFT);

  bcd_dd_engine #(
    .BIN_W (BIN_W),
    .DIG   (DIG)
  ) u_engine (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (eng_load),
    .bin   (eng_bin),
    .step  (eng_step),
    .bcd   (eng_bcd)
  );

  // FSM next state, arbitration bookkeeping and output register updates
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    gnt_d     = '0;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    tag_d     = tag_q;
    bcd_d     = bcd_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d        = SHIFT;
          gnt_d[win_idx] = 1'b1;
          tag_d          = win_idx;
          rr_d           = ID_W'((int'(win_idx) + 1) % N_REQ);
          cnt_d          = '0;
        end
      end
      SHIFT: begin
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          state_d   = DONE;
          cnt_d     = '0;
          done_d    = 1'b1;
          done_id_d = tag_q;
          bcd_d     = eng_bcd;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // All scheduler state and registered outputs; reset aborts any conversion
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      tag_q     <= '0;
      bcd_q     <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      tag_q     <= tag_d;
      bcd_q     <= bcd_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;
  assign bus.done_id = done_id_q;
  assign bus.bcd_out = bcd_q;

endmodule
